// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: default widths, standard
// 50/60 Hz line/frame timings and sync polarity encodings.
package video_timing_pkg;

    localparam int unsigned DEF_HW = 10;
    localparam int unsigned DEF_VW = 10;
    localparam int unsigned DEF_FW = 5;

    // 50 Hz raster: 448 ticks x 320 lines
    localparam int unsigned H_TOTAL_50    = 448;
    localparam int unsigned V_TOTAL_50    = 320;
    localparam int unsigned V_SYNC_BEG_50 = 8;
    localparam int unsigned V_SYNC_END_50 = 11;

    // 60 Hz raster: 448 ticks x 262 lines
    localparam int unsigned H_TOTAL_60    = 448;
    localparam int unsigned V_TOTAL_60    = 262;
    localparam int unsigned V_SYNC_BEG_60 = 4;
    localparam int unsigned V_SYNC_END_60 = 7;

    // Horizontal sync is common to both rasters
    localparam int unsigned H_SYNC_BEG_DEF = 11;
    localparam int unsigned H_SYNC_END_DEF = 43;

    localparam logic POL_ACTIVE_HIGH = 1'b1;
    localparam logic POL_ACTIVE_LOW  = 1'b0;

endpackage

// File: rtl/video_window.sv
// Half-open window decode: hit_c = (beg <= cnt < stop); beg >= stop is empty.
module video_window
    import video_timing_pkg::*;
#(
    parameter int unsigned W = DEF_HW
) (
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] beg,
    input  logic [W-1:0] stop,
    output logic         hit_c
);

    // Unsigned compare pair; an inverted window can never satisfy both terms
    assign hit_c = (cnt >= beg) && (cnt < stop);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters with per-frame shadowed timing,
// registered sync/blank/display-enable decodes, line/frame strobes,
// interlace field tracking, flash counter and a raster-position interrupt.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned HW = DEF_HW,
    parameter int unsigned VW = DEF_VW,
    parameter int unsigned FW = DEF_FW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [HW-1:0] h_total,
    input  logic [HW-1:0] h_sync_beg,
    input  logic [HW-1:0] h_sync_end,
    input  logic [HW-1:0] h_act_beg,
    input  logic [HW-1:0] h_act_end,
    input  logic [VW-1:0] v_total,
    input  logic [VW-1:0] v_sync_beg,
    input  logic [VW-1:0] v_sync_end,
    input  logic [VW-1:0] v_act_beg,
    input  logic [VW-1:0] v_act_end,
    input  logic          hs_pol,
    input  logic          vs_pol,
    input  logic          interlace,
    input  logic [HW-1:0] int_h,
    input  logic [VW-1:0] int_v,
    input  logic          int_ack,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          csync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          field,
    output logic          frame,
    output logic          flash,
    output logic          int_req
);

    logic [HW-1:0] sh_h_total, sh_h_sync_beg, sh_h_sync_end, sh_h_act_beg, sh_h_act_end;
    logic [VW-1:0] sh_v_total, sh_v_sync_beg, sh_v_sync_end, sh_v_act_beg, sh_v_act_end;
    logic          sh_hs_pol, sh_vs_pol, sh_interlace;
    logic          load_pend;
    logic [FW-1:0] flash_ctr;

    logic [HW-1:0] h_total_eff_c, h_last_c, h_half_c, v_ofs_c;
    logic [VW-1:0] v_last_c;
    logic          line_wrap_c, frame_wrap_c, int_hit_c;
    logic          hs_c, vs_c, ha_c, va_c;

    // Raster wrap points derived from the shadowed timing
    assign h_total_eff_c = (sh_h_total < HW'(2)) ? HW'(2) : sh_h_total;
    assign h_last_c      = h_total_eff_c - HW'(1);
    assign v_last_c      = (sh_interlace && field) ? sh_v_total : sh_v_total - VW'(1);
    assign line_wrap_c   = ce && (hcount >= h_last_c);
    assign frame_wrap_c  = line_wrap_c && (vcount >= v_last_c);

    // Field 1 shifts the vertical sync edges by half a line
    assign h_half_c = sh_h_total >> 1;
    assign v_ofs_c  = (sh_interlace && field) ? h_half_c : '0;

    assign int_hit_c = ce && (hcount == int_h) && (vcount == int_v) && (int_v < sh_v_total);

    video_window #(.W(HW)) u_hsync_win (
        .cnt   (hcount),
        .beg   (sh_h_sync_beg),
        .stop  (sh_h_sync_end),
        .hit_c (hs_c)
    );

    // Compare {line, tick} so the half-line offset falls out of one window
    video_window #(.W(VW + HW)) u_vsync_win (
        .cnt   ({vcount, hcount}),
        .beg   ({sh_v_sync_beg, v_ofs_c}),
        .stop  ({sh_v_sync_end, v_ofs_c}),
        .hit_c (vs_c)
    );

    video_window #(.W(HW)) u_hact_win (
        .cnt   (hcount),
        .beg   (sh_h_act_beg),
        .stop  (sh_h_act_end),
        .hit_c (ha_c)
    );

    video_window #(.W(VW)) u_vact_win (
        .cnt   (vcount),
        .beg   (sh_v_act_beg),
        .stop  (sh_v_act_end),
        .hit_c (va_c)
    );

    // Shadow timing: held through reset, reloaded on release and at each frame wrap
    always_ff @(posedge clk) begin
        load_pend <= rst;
        if (rst || load_pend || frame_wrap_c) begin
            sh_h_total    <= h_total;
            sh_h_sync_beg <= h_sync_beg;
            sh_h_sync_end <= h_sync_end;
            sh_h_act_beg  <= h_act_beg;
            sh_h_act_end  <= h_act_end;
            sh_v_total    <= v_total;
            sh_v_sync_beg <= v_sync_beg;
            sh_v_sync_end <= v_sync_end;
            sh_v_act_beg  <= v_act_beg;
            sh_v_act_end  <= v_act_end;
            sh_hs_pol     <= hs_pol;
            sh_vs_pol     <= vs_pol;
            sh_interlace  <= interlace;
        end
    end

    // Raster counters, field, flash counter and interrupt latch
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount    <= '0;
            vcount    <= '0;
            field     <= 1'b0;
            flash_ctr <= '0;
            int_req   <= 1'b0;
        end else begin
            if (line_wrap_c) begin
                hcount <= '0;
            end else if (ce) begin
                hcount <= hcount + HW'(1);
            end

            if (frame_wrap_c) begin
                vcount    <= '0;
                field     <= sh_interlace ? ~field : 1'b0;
                flash_ctr <= flash_ctr + FW'(1);
            end else if (line_wrap_c) begin
                vcount <= vcount + VW'(1);
            end

            if (int_hit_c) begin
                int_req <= 1'b1;
            end else if (int_ack) begin
                int_req <= 1'b0;
            end
        end
    end

    // Registered decodes, one clk behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= ~hs_pol;
            vsync       <= ~vs_pol;
            csync       <= 1'b1;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= ~(hs_c ^ sh_hs_pol);
            vsync       <= ~(vs_c ^ sh_vs_pol);
            csync       <= ~(hs_c ^ vs_c);
            hblank      <= ~ha_c;
            vblank      <= ~va_c;
            de          <= ha_c & va_c;
            line_start  <= line_wrap_c;
            frame_start <= frame_wrap_c;
        end
    end

    assign frame = flash_ctr[0];
    assign flash = flash_ctr[FW-1];

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a scaled-down 20x10 raster.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int unsigned HW = 10;
    localparam int unsigned VW = 10;
    localparam int unsigned FW = 5;

    logic          clk, rst, ce;
    logic [HW-1:0] h_total, h_sync_beg, h_sync_end, h_act_beg, h_act_end;
    logic [VW-1:0] v_total, v_sync_beg, v_sync_end, v_act_beg, v_act_end;
    logic          hs_pol, vs_pol, interlace;
    logic [HW-1:0] int_h;
    logic [VW-1:0] int_v;
    logic          int_ack;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          hsync, vsync, csync, hblank, vblank, de;
    logic          line_start, frame_start, field, frame, flash, int_req;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    logic        ce_div   = 1'b1;
    logic        ce_off   = 1'b0;

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;

    typedef struct packed {
        logic hs, vs, hb, vb, de, cs, ls, fs;
    } dec_t;

    exp_t sbq[$];
    dec_t dq[$];
    int   iq[$];

    video_timing_gen #(.HW(HW), .VW(VW), .FW(FW)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .h_total(h_total), .h_sync_beg(h_sync_beg), .h_sync_end(h_sync_end),
        .h_act_beg(h_act_beg), .h_act_end(h_act_end),
        .v_total(v_total), .v_sync_beg(v_sync_beg), .v_sync_end(v_sync_end),
        .v_act_beg(v_act_beg), .v_act_end(v_act_end),
        .hs_pol(hs_pol), .vs_pol(vs_pol), .interlace(interlace),
        .int_h(int_h), .int_v(int_v), .int_ack(int_ack),
        .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .csync(csync),
        .hblank(hblank), .vblank(vblank), .de(de),
        .line_start(line_start), .frame_start(frame_start),
        .field(field), .frame(frame), .flash(flash), .int_req(int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel tick: every clk, every 2nd clk, or frozen
    always @(posedge clk) begin
        #1;
        if (ce_off)      ce = 1'b0;
        else if (ce_div) ce = ~ce;
        else             ce = 1'b1;
    end

    function automatic logic win(int c, int b, int e);
        return (c >= b) && (c < e);
    endfunction

    task automatic cfg_default();
        h_total = 20; h_sync_beg = 2; h_sync_end = 6; h_act_beg = 8; h_act_end = 18;
        v_total = 10; v_sync_beg = 1; v_sync_end = 3; v_act_beg = 4; v_act_end = 9;
        hs_pol = POL_ACTIVE_HIGH; vs_pol = POL_ACTIVE_HIGH; interlace = 1'b0;
        int_h = 0; int_v = 0; int_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] obs[$];
        exp_t        e;
        logic [31:0] o;
        cfg_default();
        hs_pol = POL_ACTIVE_LOW; vs_pol = POL_ACTIVE_LOW; ce_div = 1'b0;
        do_reset();
        repeat (230) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sbq.push_back('{"hcount", 32'd0});      obs.push_back(32'(hcount));
        sbq.push_back('{"vcount", 32'd0});      obs.push_back(32'(vcount));
        sbq.push_back('{"field", 32'd0});       obs.push_back(32'(field));
        sbq.push_back('{"frame", 32'd0});       obs.push_back(32'(frame));
        sbq.push_back('{"flash", 32'd0});       obs.push_back(32'(flash));
        sbq.push_back('{"int_req", 32'd0});     obs.push_back(32'(int_req));
        sbq.push_back('{"line_start", 32'd0});  obs.push_back(32'(line_start));
        sbq.push_back('{"frame_start", 32'd0}); obs.push_back(32'(frame_start));
        sbq.push_back('{"hblank", 32'd1});      obs.push_back(32'(hblank));
        sbq.push_back('{"vblank", 32'd1});      obs.push_back(32'(vblank));
        sbq.push_back('{"de", 32'd0});          obs.push_back(32'(de));
        sbq.push_back('{"hsync", 32'd1});       obs.push_back(32'(hsync));
        sbq.push_back('{"vsync", 32'd1});       obs.push_back(32'(vsync));
        sbq.push_back('{"csync", 32'd1});       obs.push_back(32'(csync));
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = obs.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL reset_%s got=%0d exp=%0d", e.nm, o, e.v);
            end
        end
    endtask

    task automatic test_decode();
        dec_t        e, o;
        int          fs_seen = 0;
        int unsigned t_fs    = 0;
        int          hs_cnt  = 0;
        int          de_cnt  = 0;
        logic [HW-1:0] h0;
        cfg_default(); ce_div = 1'b1;
        do_reset();
        iq.delete();
        iq.push_back(400); iq.push_back(400);
        for (int i = 0; i < 1200 && fs_seen < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = dq.pop_front();
                o = {hsync, vsync, hblank, vblank, de, csync, line_start, frame_start};
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL decode cyc=%0d got=%b exp=%b", cyc, o, e);
                end
            end
            if (frame_start) begin
                if (fs_seen > 0) begin
                    checks++;
                    if (int'(cyc - t_fs) !== iq[0]) begin
                        failures++;
                        $display("FAIL frame_period got=%0d exp=%0d", cyc - t_fs, iq[0]);
                    end
                    void'(iq.pop_front());
                    checks++;
                    if (hs_cnt !== 80) begin
                        failures++;
                        $display("FAIL hsync_clks got=%0d exp=80", hs_cnt);
                    end
                    checks++;
                    if (de_cnt !== 100) begin
                        failures++;
                        $display("FAIL de_clks got=%0d exp=100", de_cnt);
                    end
                end
                fs_seen++; t_fs = cyc; hs_cnt = 0; de_cnt = 0;
            end
            hs_cnt += int'(hsync);
            de_cnt += int'(de);
            e.hs = win(int'(hcount), 2, 6);
            e.vs = win(int'(vcount), 1, 3);
            e.hb = ~win(int'(hcount), 8, 18);
            e.vb = ~win(int'(vcount), 4, 9);
            e.de = ~e.hb & ~e.vb;
            e.cs = ~(e.hs ^ e.vs);
            e.ls = ce && (hcount >= 19);
            e.fs = e.ls && (vcount >= 9);
            dq.push_back(e);
        end
        dq.delete();
        checks++;
        if (fs_seen < 3) begin
            failures++;
            $display("FAIL decode_timeout got=%0d exp=3", fs_seen);
        end
        ce_off = 1'b1;
        repeat (2) @(negedge clk);
        h0 = hcount;
        repeat (6) @(negedge clk);
        checks++;
        if (hcount !== h0) begin
            failures++;
            $display("FAIL ce_hold got=%0d exp=%0d", hcount, h0);
        end
        ce_off = 1'b0;
    endtask

    task automatic test_interlace();
        int          fs_seen = 0;
        int unsigned t_fs    = 0;
        int          rises   = 0;
        int          fq[$];
        logic        pv_vs = 1'b0, pv_f = 1'b0;
        int          pv_h = 0, pv_v = 0;
        int          ev;
        cfg_default(); interlace = 1'b1; ce_div = 1'b1;
        do_reset();
        iq.delete();
        iq.push_back(440); iq.push_back(400); iq.push_back(440);
        fq.push_back(1); fq.push_back(0); fq.push_back(1); fq.push_back(0);
        for (int i = 0; i < 2500 && fs_seen < 4; i++) begin
            @(negedge clk);
            if (i > 0 && vsync && !pv_vs) begin
                rises++;
                ev = pv_f ? 10 : 0;
                checks++;
                if (pv_h !== ev || pv_v !== 1) begin
                    failures++;
                    $display("FAIL vsync_rise got=(%0d,%0d) exp=(%0d,1)", pv_h, pv_v, ev);
                end
            end
            if (i > 0 && !vsync && pv_vs) begin
                ev = pv_f ? 10 : 0;
                checks++;
                if (pv_h !== ev || pv_v !== 3) begin
                    failures++;
                    $display("FAIL vsync_fall got=(%0d,%0d) exp=(%0d,3)", pv_h, pv_v, ev);
                end
            end
            if (frame_start) begin
                checks++;
                if (int'(field) !== fq[0]) begin
                    failures++;
                    $display("FAIL field got=%0d exp=%0d", field, fq[0]);
                end
                void'(fq.pop_front());
                if (fs_seen > 0) begin
                    checks++;
                    if (int'(cyc - t_fs) !== iq[0]) begin
                        failures++;
                        $display("FAIL il_period got=%0d exp=%0d", cyc - t_fs, iq[0]);
                    end
                    void'(iq.pop_front());
                end
                fs_seen++; t_fs = cyc;
            end
            pv_vs = vsync; pv_f = field; pv_h = int'(hcount); pv_v = int'(vcount);
        end
        checks++;
        if (fs_seen < 4 || rises !== 4) begin
            failures++;
            $display("FAIL il_count frames=%0d rises=%0d exp=4/4", fs_seen, rises);
        end
    endtask

    task automatic test_shadow();
        int          ok      = 0;
        int          fs_seen = 0;
        int unsigned t_ls    = 0;
        int unsigned t_fs    = 0;
        logic        in_new  = 1'b0;
        cfg_default(); ce_div = 1'b1;
        do_reset();
        iq.delete();
        for (int i = 0; i < 400 && ok == 0; i++) begin
            @(negedge clk);
            if (vcount == 3) ok = 1;
        end
        h_total = 16;
        for (int i = 0; i < 1200 && fs_seen < 2; i++) begin
            @(negedge clk);
            if (line_start) begin
                if (iq.size() > 0) begin
                    checks++;
                    if (int'(cyc - t_ls) !== iq[0]) begin
                        failures++;
                        $display("FAIL line_period got=%0d exp=%0d", cyc - t_ls, iq[0]);
                    end
                    void'(iq.pop_front());
                end
                if (frame_start) begin
                    if (fs_seen > 0) begin
                        checks++;
                        if (cyc - t_fs !== 320) begin
                            failures++;
                            $display("FAIL new_frame_period got=%0d exp=320", cyc - t_fs);
                        end
                    end
                    fs_seen++; t_fs = cyc; in_new = 1'b1;
                end
                iq.push_back(in_new ? 32 : 40);
                t_ls = cyc;
            end
        end
        iq.delete();
        checks++;
        if (fs_seen < 2) begin
            failures++;
            $display("FAIL shadow_timeout got=%0d exp=2", fs_seen);
        end
    endtask

    task automatic test_interrupt();
        int ok = 0;
        int highs = 0;
        int seen10 = 0;
        cfg_default(); ce_div = 1'b1; int_h = 5; int_v = 2;
        do_reset();
        @(negedge clk);
        checks++;
        if (int_req !== 1'b0) begin
            failures++;
            $display("FAIL int_idle got=%0b exp=0", int_req);
        end
        for (int i = 0; i < 600 && ok == 0; i++) begin
            @(negedge clk);
            if (int_req) ok = 1;
        end
        checks++;
        if (ok == 0 || hcount !== 6 || vcount !== 2) begin
            failures++;
            $display("FAIL int_rise got=(%0d,%0d) exp=(6,2)", hcount, vcount);
        end
        repeat (4) @(negedge clk);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        checks++;
        if (int_req !== 1'b0) begin
            failures++;
            $display("FAIL int_clear got=%0b exp=0", int_req);
        end
        ok = 0;
        for (int i = 0; i < 900 && ok == 0; i++) begin
            @(negedge clk);
            if (hcount == 5 && vcount == 2 && ce) ok = 1;
        end
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        checks++;
        if (ok == 0 || int_req !== 1'b1) begin
            failures++;
            $display("FAIL int_set_wins got=%0b exp=1", int_req);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (int_req !== 1'b1) begin
            failures++;
            $display("FAIL int_hold got=%0b exp=1", int_req);
        end
        cfg_default(); interlace = 1'b1; int_h = 5; int_v = 10;
        do_reset();
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            highs += int'(int_req);
            if (vcount == 10) seen10 = 1;
        end
        checks++;
        if (highs !== 0 || seen10 !== 1) begin
            failures++;
            $display("FAIL int_out_of_range highs=%0d line10=%0d exp=0/1", highs, seen10);
        end
    endtask

    task automatic test_reset_mid();
        int ok = 0;
        int hs_cnt = 0;
        cfg_default(); ce_div = 1'b1;
        do_reset();
        for (int i = 0; i < 500 && ok == 0; i++) begin
            @(negedge clk);
            if (frame_start) ok = 1;
        end
        ok = 0;
        for (int i = 0; i < 500 && ok == 0; i++) begin
            @(negedge clk);
            if (hcount == 12 && vcount == 5) ok = 1;
        end
        rst = 1'b1;
        h_sync_beg = 6; h_sync_end = 2;
        @(negedge clk);
        checks++;
        if (ok == 0 || hcount !== 0 || vcount !== 0 || de !== 1'b0 || frame !== 1'b0
            || flash !== 1'b0 || hblank !== 1'b1 || hsync !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got h=%0d v=%0d de=%0b fr=%0b hb=%0b hs=%0b exp 0,0,0,0,1,0",
                     hcount, vcount, de, frame, hblank, hsync);
        end
        rst = 1'b0;
        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            hs_cnt += int'(hsync);
        end
        checks++;
        if (hs_cnt !== 0) begin
            failures++;
            $display("FAIL empty_hsync got=%0d exp=0", hs_cnt);
        end
    endtask

    task automatic test_flash();
        int       ok;
        int       ff[$];
        int       e;
        int unsigned t_ls;
        cfg_default();
        h_total = 4; h_sync_beg = 1; h_sync_end = 2; h_act_beg = 0; h_act_end = 3;
        v_total = 4; v_sync_beg = 1; v_sync_end = 2; v_act_beg = 0; v_act_end = 3;
        ce_div = 1'b0;
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            ff.push_back(((k >> 4) & 1) * 2 + (k & 1));
            ok = 0;
            for (int i = 0; i < 40 && ok == 0; i++) begin
                @(negedge clk);
                if (frame_start) ok = 1;
            end
            e = ff.pop_front();
            checks++;
            if (ok == 0 || int'({flash, frame}) !== e) begin
                failures++;
                $display("FAIL flash_frame k=%0d got=%0d exp=%0d", k, {flash, frame}, e);
            end
        end
        for (int t = 0; t < 2; t++) begin
            h_total = HW'(t);
            do_reset();
            t_ls = 0;
            ok = 0;
            for (int i = 0; i < 20 && ok < 2; i++) begin
                @(negedge clk);
                if (line_start) begin
                    if (ok == 1) begin
                        checks++;
                        if (cyc - t_ls !== 2) begin
                            failures++;
                            $display("FAIL min_h_total ht=%0d got=%0d exp=2", t, cyc - t_ls);
                        end
                    end
                    ok++;
                    t_ls = cyc;
                end
            end
            checks++;
            if (ok < 2) begin
                failures++;
                $display("FAIL min_h_total_timeout ht=%0d got=%0d exp=2", t, ok);
            end
        end
        ce_div = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        cfg_default();
        repeat (3) @(negedge clk);
        test_reset();
        test_decode();
        test_interlace();
        test_shadow();
        test_interrupt();
        test_reset_mid();
        test_flash();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 HW, default 10: width of horizontal counter and horizontal timing fields.
REQ-002 VW, default 10: width of vertical counter and vertical timing fields.
REQ-003 FW, default 5: width of the flash/frame counter.
REQ-004 clk  input  1: system clock; all state changes on posedge clk.
REQ-005 rst  input  1: reset, synchronous, active-high.
REQ-006 ce  input  1: pixel-tick enable; raster counters advance only on clocks with ce=1.
REQ-007 h_total, h_sync_beg, h_sync_end, h_act_beg, h_act_end  input  HW each: line timing in pixel ticks.
REQ-008 v_total, v_sync_beg, v_sync_end, v_act_beg, v_act_end  input  VW each: frame timing in lines.
REQ-009 hs_pol, vs_pol, interlace  input  1 each: sync polarity (1 = active-high); interlaced-mode enable.
REQ-010 int_h  input  HW; int_v  input  VW; int_ack  input  1: raster interrupt position; interrupt acknowledge.
REQ-011 hcount  output  HW; vcount  output  VW: current raster position.
REQ-012 hsync, vsync  output  1: polarity-adjusted syncs; csync  output  1: active-low composite sync.
REQ-013 hblank, vblank, de  output  1: blanking flags; display enable.
REQ-014 line_start, frame_start  output  1: single-clk strobes.
REQ-015 field, frame, flash  output  1: interlace field; flash_ctr[0]; flash_ctr[FW-1].
REQ-016 int_req  output  1: level raster interrupt request.

Function
REQ-017 Shadow regs capture all timing and polarity inputs on the first clk after rst and at every frame wrap; mid-frame input changes take effect from the next frame only.
REQ-018 Line wrap = ce tick with hcount >= sh_h_total-1: hcount <= 0, else hcount+1; h_total values 0 or 1 are treated as 2.
REQ-019 vcount advances only on line wrap; vlast = v_total-1 (progressive or field=0), v_total (interlace, field=1); vcount >= vlast on line wrap -> 0 (frame wrap).
REQ-020 field toggles at frame wrap when sh_interlace=1; is forced 0 at frame wrap when sh_interlace=0.
REQ-021 Window rule: flag = (beg <= cnt < end); beg >= end gives an empty window.
REQ-022 hs = window(hcount, h_sync_beg, h_sync_end); hsync = hs when hs_pol=1, ~hs otherwise.
REQ-023 vs = window(vcount, v_sync_beg, v_sync_end), except interlace field=1: vs rises at hcount = h_total/2 (floor) of line v_sync_beg and falls at hcount = h_total/2 of line v_sync_end (half-line offset).
REQ-024 vsync = vs when vs_pol=1, ~vs otherwise; csync = ~(hs ^ vs).
REQ-025 hblank = ~window(hcount, h_act_beg, h_act_end); vblank = ~window(vcount, v_act_beg, v_act_end); de = ~hblank & ~vblank.
REQ-026 hsync, vsync, csync, hblank, vblank, de are registered decodes of hcount/vcount and lag them by exactly one clk.
REQ-027 line_start is high for exactly one clk: the clk after a line wrap, coincident with hcount=0 first appearing; frame_start is the same for frame wrap.
REQ-028 flash_ctr increments modulo 2^FW at each frame wrap.
REQ-029 int_req sets on the ce tick where hcount==int_h and vcount==int_v, and clears on int_ack; simultaneous set and ack leaves it set; if int_v >= v_total, int_req never sets.

Reset
REQ-030 rst: hcount=0, vcount=0, field=0, flash_ctr=0, int_req=0, line_start=frame_start=0, hblank=vblank=1, de=0, hsync/vsync inactive per hs_pol/vs_pol, csync=1.
REQ-031 rst dominates ce and int_ack; reset mid-frame restarts the raster at (0,0) with shadows reloaded on release.

Structure
REQ-032 The shared package video_timing_pkg holds the default timing constants (50 Hz: 448x320, hsync 11..43, vsync 8..11; 60 Hz: 448x262, vsync 4..7) and the polarity constants.
REQ-033 A single parametrised sub-module, video_window (W, cnt, beg, end -> in), is instantiated once each for the hsync, vsync, h-active and v-active decodes.

Verification
REQ-034 Defaults 448x320, ce every 2nd clk, hs_pol=1, h_sync 11..43 -> frame_start every 286720 clk; hsync high 64 clk per line.
REQ-035 interlace=1, v_total=312, h_total=448 -> frames alternate 312/313 lines, field toggles each frame, field-1 vsync rises at hcount=224.
REQ-036 h_total changed 448->400 at vcount=100 -> current frame keeps 448-tick lines; the next frame's lines are 400 ticks.
REQ-037 int_h=10, int_v=5 -> int_req rises 1 clk after the ce tick at (10,5); int_ack on the next frame's matching tick -> int_req stays 1.
REQ-038 rst at (200,100) -> next clk hcount=0, vcount=0, de=0, flash_ctr=0; then h_sync_beg=50, h_sync_end=40 -> hsync never active.
REQ-039 FW=5 -> over 32 frames, flash toggles every 16 frames and frame toggles every frame.
